dmem_bank: RTL

DMEM_BANK -- requirements
Module: dmem_bank

---
 rtl/dmem_bank.sv | 153 +++++++++++++++
 1 files changed

// File: rtl/dmem_bank.sv
// Single-port data memory bank with byte/half/word access and a power-on clearing sweep.
// Requests are accepted only after the sweep completes; each acceptance yields a one-cycle response.
module dmem_bank #(
    parameter int unsigned DEPTH = 64
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_wr,
    input  logic [31:0] req_addr,
    input  logic [1:0]  req_size,
    input  logic        req_unsigned,
    input  logic [31:0] req_wdata,
    output logic        rsp_valid,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err,
    output logic        init_done
);

    localparam int unsigned IDX_W = $clog2(DEPTH);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DEPTH - 1);

    typedef enum logic {
        ST_INIT,
        ST_RUN
    } state_t;

    state_t           state, state_nxt;
    logic [IDX_W-1:0] idx, idx_nxt;
    logic [31:0]      mem [DEPTH];

    logic             accept_c;
    logic [IDX_W-1:0] widx_c;
    logic [31:0]      hi_c;
    logic [31:0]      rd_word_c;
    logic             err_c;
    logic [7:0]       lane_b_c;
    logic [15:0]      lane_h_c;
    logic [31:0]      load_c;
    logic [31:0]      wr_word_c;

    assign req_ready = (state == ST_RUN);
    assign init_done = (state == ST_RUN);
    assign accept_c  = req_valid && req_ready;
    assign widx_c    = req_addr[IDX_W+1:2];
    assign hi_c      = req_addr >> (IDX_W + 2);
    assign rd_word_c = mem[widx_c];

    // State and sweep index register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_INIT;
            idx   <= '0;
        end else begin
            state <= state_nxt;
            idx   <= idx_nxt;
        end
    end

    // Sweep sequencing: leave INIT on the cycle the last word is cleared
    always_comb begin
        state_nxt = state;
        idx_nxt   = idx;
        case (state)
            ST_INIT: begin
                idx_nxt = idx + IDX_W'(1);
                if (idx == LAST_IDX) begin
                    state_nxt = ST_RUN;
                end
            end
            default: ;
        endcase
    end

    // Size, alignment and range checks
    always_comb begin
        err_c = 1'b0;
        case (req_size)
            2'b00: ;
            2'b01: if (req_addr[0]) err_c = 1'b1;
            2'b10: if (req_addr[1:0] != 2'b00) err_c = 1'b1;
            default: err_c = 1'b1;
        endcase
        if (hi_c != 32'd0) begin
            err_c = 1'b1;
        end
    end

    // Load lane extraction and extension
    always_comb begin
        case (req_addr[1:0])
            2'd1:    lane_b_c = rd_word_c[15:8];
            2'd2:    lane_b_c = rd_word_c[23:16];
            2'd3:    lane_b_c = rd_word_c[31:24];
            default: lane_b_c = rd_word_c[7:0];
        endcase
        lane_h_c = req_addr[1] ? rd_word_c[31:16] : rd_word_c[15:0];
        case (req_size)
            2'b00:   load_c = req_unsigned ? {24'd0, lane_b_c} : {{24{lane_b_c[7]}}, lane_b_c};
            2'b01:   load_c = req_unsigned ? {16'd0, lane_h_c} : {{16{lane_h_c[15]}}, lane_h_c};
            default: load_c = rd_word_c;
        endcase
    end

    // Store merge preserving untouched lanes
    always_comb begin
        wr_word_c = rd_word_c;
        case (req_size)
            2'b00: begin
                case (req_addr[1:0])
                    2'd1:    wr_word_c[15:8]  = req_wdata[7:0];
                    2'd2:    wr_word_c[23:16] = req_wdata[7:0];
                    2'd3:    wr_word_c[31:24] = req_wdata[7:0];
                    default: wr_word_c[7:0]   = req_wdata[7:0];
                endcase
            end
            2'b01: begin
                if (req_addr[1]) begin
                    wr_word_c[31:16] = req_wdata[15:0];
                end else begin
                    wr_word_c[15:0] = req_wdata[15:0];
                end
            end
            default: wr_word_c = req_wdata;
        endcase
    end

    // Storage array; cleared only by the INIT sweep
    always_ff @(posedge clk) begin
        if (state == ST_INIT) begin
            mem[idx] <= '0;
        end else if (accept_c && req_wr && !err_c) begin
            mem[widx_c] <= wr_word_c;
        end
    end

    // Response registers; data and error hold between responses
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rsp_valid <= 1'b0;
            rsp_rdata <= '0;
            rsp_err   <= 1'b0;
        end else begin
            rsp_valid <= accept_c;
            if (accept_c) begin
                rsp_err   <= err_c;
                rsp_rdata <= (err_c || req_wr) ? 32'd0 : load_c;
            end
        end
    end

endmodule
